// File: rtl/elevator_queue_reader_pkg.sv
// Shared types and constants for the elevator queue reader.
// State codes double as the debug code driven on estado.
package elevator_queue_reader_pkg;

  localparam int FLOOR_W = 4;
  localparam logic [FLOOR_W-1:0] EMPTY_SLOT = 4'd0;
  localparam logic [FLOOR_W-1:0] GROUND_FLOOR = 4'd1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_MOVE_UP   = 3'd2,
    S_MOVE_DOWN = 3'd3,
    S_DOOR_OPEN = 3'd4,
    S_POP       = 3'd5,
    S_SETTLE    = 3'd6
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elevator_queue_reader_tick_timer.sv
// Loadable down-counter; done is high on the last cycle of a load.
// Shared by the travel and door phases.
module elevator_queue_reader_tick_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/elevator_queue_reader.sv
// Queue consumer: serves the head request floor by floor,
// opens the door on arrival, then pops the head.
module elevator_queue_reader
  import elevator_queue_reader_pkg::*;
#(
  parameter int TICKS_PER_FLOOR = 50,
  parameter int DOOR_TICKS      = 100
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [FLOOR_W-1:0] q_head,
  output logic [FLOOR_W-1:0] rd_addr,
  output logic               shift,
  output logic               pop_busy,
  output logic [FLOOR_W-1:0] andar_atual,
  output logic               motor_sobe,
  output logic               motor_desce,
  output logic               porta_aberta,
  output logic               ocupado,
  output logic [2:0]         estado
);

  localparam int TW =
    $clog2(max2(TICKS_PER_FLOOR, DOOR_TICKS) + 1);

  state_e state, state_nx;
  logic [FLOOR_W-1:0] andar, andar_nx;
  logic [FLOOR_W-1:0] target, target_nx;
  logic t_load, t_done;
  logic [TW-1:0] t_val;

  elevator_queue_reader_tick_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      andar  <= GROUND_FLOOR;
      target <= EMPTY_SLOT;
    end else begin
      state  <= state_nx;
      andar  <= andar_nx;
      target <= target_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    andar_nx  = andar;
    target_nx = target;
    t_load    = 1'b0;
    t_val     = TW'(DOOR_TICKS);
    unique case (state)
      S_IDLE: begin
        if (enable && q_head != EMPTY_SLOT) begin
          state_nx  = S_CHECK;
          target_nx = q_head;
        end
      end
      // Head is re-read every floor so a nearer insert wins.
      S_CHECK: begin
        t_load = 1'b1;
        if (!enable) begin
          state_nx = S_IDLE;
        end else begin
          target_nx = q_head;
          if (q_head == EMPTY_SLOT) begin
            state_nx = S_IDLE;
          end else if (q_head > andar) begin
            state_nx = S_MOVE_UP;
            t_val    = TW'(TICKS_PER_FLOOR);
          end else if (q_head < andar) begin
            state_nx = S_MOVE_DOWN;
            t_val    = TW'(TICKS_PER_FLOOR);
          end else begin
            state_nx = S_DOOR_OPEN;
          end
        end
      end
      S_MOVE_UP: begin
        if (t_done) begin
          state_nx = S_CHECK;
          if (andar < target) andar_nx = andar + 4'd1;
        end
      end
      S_MOVE_DOWN: begin
        if (t_done) begin
          state_nx = S_CHECK;
          if (andar > target) andar_nx = andar - 4'd1;
        end
      end
      S_DOOR_OPEN: begin
        if (t_done) state_nx = S_POP;
      end
      S_POP:    state_nx = S_SETTLE;
      S_SETTLE: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign rd_addr      = 4'd0;
  assign shift        = (state == S_POP) && (q_head != EMPTY_SLOT);
  assign pop_busy     = (state == S_POP) || (state == S_SETTLE);
  assign andar_atual  = andar;
  assign motor_sobe   = (state == S_MOVE_UP);
  assign motor_desce  = (state == S_MOVE_DOWN);
  assign porta_aberta = (state == S_DOOR_OPEN);
  assign ocupado      = (state != S_IDLE);
  assign estado       = state;

endmodule

// File: tb/tb_elevator_queue_reader.sv
// Bench for elevator_queue_reader: timeline model plus
// directed scenarios with hand-derived cycle counts.
module tb_elevator_queue_reader;

  localparam int TPF = 4;
  localparam int DT  = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] q_head = 4'd0;
  logic [3:0] rd_addr;
  logic       shift;
  logic       pop_busy;
  logic [3:0] andar_atual;
  logic       motor_sobe;
  logic       motor_desce;
  logic       porta_aberta;
  logic       ocupado;
  logic [2:0] estado;

  elevator_queue_reader #(
    .TICKS_PER_FLOOR (TPF),
    .DOOR_TICKS      (DT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .q_head       (q_head),
    .rd_addr      (rd_addr),
    .shift        (shift),
    .pop_busy     (pop_busy),
    .andar_atual  (andar_atual),
    .motor_sobe   (motor_sobe),
    .motor_desce  (motor_desce),
    .porta_aberta (porta_aberta),
    .ocupado      (ocupado),
    .estado       (estado)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  int rst_cnt = 0;
  always @(negedge reset_n) rst_cnt++;

  int checks = 0;
  int errors = 0;

  // Timeline model: walks through the request lifecycle
  int         m_floor = 1;
  int         seen = 0;
  bit         ab = 1'b0;
  logic [2:0] e_st = 3'd0;
  logic       e_up = 1'b0, e_dn = 1'b0, e_door = 1'b0;
  logic       e_sh = 1'b0, e_busy = 1'b0;

  task automatic show(input logic [2:0] st, input logic up,
                      input logic dn, input logic door,
                      input logic sh, input logic busy);
    e_st = st; e_up = up; e_dn = dn;
    e_door = door; e_sh = sh; e_busy = busy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #3;
    if (!reset_n || rst_cnt != seen) ab = 1'b1;
  endtask

  task automatic serve();
    int tgt;
    int step;
    bit up;
    step = 0;
    forever begin
      cyc();
      if (ab) return;
      m_floor += step;
      step = 0;
      show(3'd1, 0, 0, 0, 0, 0);
      if (!enable || q_head == 4'd0) return;
      tgt = int'(q_head);
      if (tgt == m_floor) begin
        for (int k = 0; k < DT; k++) begin
          cyc();
          if (ab) return;
          show(3'd4, 0, 0, 1, 0, 0);
        end
        cyc();
        if (ab) return;
        show(3'd5, 0, 0, 0, q_head != 4'd0, 1);
        cyc();
        if (ab) return;
        show(3'd6, 0, 0, 0, 0, 1);
        return;
      end
      up = (tgt > m_floor);
      for (int k = 0; k < TPF; k++) begin
        cyc();
        if (ab) return;
        show(up ? 3'd2 : 3'd3, up, !up, 0, 0, 0);
      end
      step = up ? 1 : -1;
    end
  endtask

  initial begin
    forever begin
      if (!ab) cyc();
      if (ab) begin
        m_floor = 1;
        seen = rst_cnt;
        ab = 1'b0;
      end
      show(3'd0, 0, 0, 0, 0, 0);
      if (reset_n && enable && q_head != 4'd0) serve();
    end
  end

  // Bench-side queue and observation counters
  logic [3:0] q[$];
  int popped = 0;
  int up_cnt = 0, dn_cnt = 0, door_cnt = 0, busy_cnt = 0;
  int sh_tot = 0;
  int sh_cyc[$];
  int sh_fl[$];

  task automatic upd();
    q_head = (q.size() > 0) ? q[0] : 4'd0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      while (popped < sh_tot) begin
        if (q.size() > 0) q.delete(0);
        popped++;
      end
      upd();
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k;
    k = 0;
    do begin
      tick(1);
      k++;
    end while ((ocupado || q.size() != 0) && k < budget);
    chk({nm, "_done"}, int'(ocupado || q.size() != 0), 0);
  endtask

  function automatic int sh_at(input int idx, input int base);
    return (idx < sh_cyc.size()) ? sh_cyc[idx] - base : -1;
  endfunction

  function automatic int fl_at(input int idx);
    return (idx < sh_fl.size()) ? sh_fl[idx] : -1;
  endfunction

  initial begin
    int start, s_up, s_dn, s_door, s_busy, s_sh;
    fork
      begin : cmp
        forever begin
          @(negedge clk);
          checks++;
          if ({estado, andar_atual, motor_sobe, motor_desce,
               porta_aberta, shift, pop_busy, ocupado, rd_addr}
              !== {e_st, 4'(m_floor), e_up, e_dn, e_door, e_sh,
                   e_busy, (e_st != 3'd0), 4'd0}) begin
            errors++;
            $display("FAIL cycle %0d: got st=%0d fl=%0d up=%b dn=%b door=%b sh=%b busy=%b ocu=%b rd=%0d, want st=%0d fl=%0d up=%b dn=%b door=%b sh=%b busy=%b",
                     cyc_n, estado, andar_atual, motor_sobe,
                     motor_desce, porta_aberta, shift, pop_busy,
                     ocupado, rd_addr, e_st, m_floor, e_up, e_dn,
                     e_door, e_sh, e_busy);
          end
          up_cnt   += int'(motor_sobe);
          dn_cnt   += int'(motor_desce);
          door_cnt += int'(porta_aberta);
          busy_cnt += int'(pop_busy);
          if (shift) begin
            sh_tot++;
            sh_cyc.push_back(cyc_n);
            sh_fl.push_back(int'(andar_atual));
          end
        end
      end
      begin : stim
        // Empty queue with enable held: nothing moves
        reset_n = 1'b0; enable = 1'b1; q_head = 4'd0;
        tick(3);
        reset_n = 1'b1;
        s_up = up_cnt; s_dn = dn_cnt; s_door = door_cnt;
        s_busy = busy_cnt; s_sh = sh_tot;
        tick(50);
        chk("t1_andar", int'(andar_atual), 1);
        chk("t1_state", int'(estado), 0);
        chk("t1_activity", (up_cnt - s_up) + (dn_cnt - s_dn) +
            (door_cnt - s_door) + (busy_cnt - s_busy) +
            (sh_tot - s_sh), 0);

        // Head equals current floor
        s_up = up_cnt; s_door = door_cnt; s_busy = busy_cnt;
        s_sh = sh_tot;
        q = {4'd1}; upd(); start = cyc_n;
        wait_idle(40, "t2");
        chk("t2_shifts", sh_tot - s_sh, 1);
        chk("t2_shift_cycle", sh_at(s_sh, start), 5);
        chk("t2_door", door_cnt - s_door, 3);
        chk("t2_busy", busy_cnt - s_busy, 2);
        chk("t2_motor", up_cnt - s_up, 0);

        // Floor 1 to 4
        s_up = up_cnt; s_door = door_cnt; s_sh = sh_tot;
        q = {4'd4}; upd(); start = cyc_n;
        wait_idle(100, "t3");
        chk("t3_up", up_cnt - s_up, 12);
        chk("t3_andar", int'(andar_atual), 4);
        chk("t3_shifts", sh_tot - s_sh, 1);
        chk("t3_shift_cycle", sh_at(s_sh, start), 20);
        chk("t3_door", door_cnt - s_door, 3);

        // From 5 toward 1 with 3 inserted at the head
        q = {4'd5}; upd();
        wait_idle(100, "t4a");
        chk("t4_start_floor", int'(andar_atual), 5);
        s_dn = dn_cnt; s_door = door_cnt; s_sh = sh_tot;
        q = {4'd1}; upd(); start = cyc_n;
        tick(3);
        q.push_front(4'd3); upd();
        wait_idle(150, "t4");
        chk("t4_shifts", sh_tot - s_sh, 2);
        chk("t4_first_shift", sh_at(s_sh, start), 15);
        chk("t4_first_floor", fl_at(s_sh), 3);
        chk("t4_andar", int'(andar_atual), 1);
        chk("t4_down", dn_cnt - s_dn, 16);
        chk("t4_door", door_cnt - s_door, 6);

        // Async reset while moving down
        q = {4'd3}; upd();
        wait_idle(100, "t5a");
        q = {4'd1}; upd(); s_sh = sh_tot;
        tick(3);
        chk("t5_moving", int'(motor_desce), 1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_motor", int'(motor_desce), 0);
        chk("t5_rst_andar", int'(andar_atual), 1);
        chk("t5_rst_ocupado", int'(ocupado), 0);
        chk("t5_rst_state", int'(estado), 0);
        q.delete(); upd();
        tick(3);
        reset_n = 1'b1;
        tick(10);
        chk("t5_no_shift", sh_tot - s_sh, 0);
        chk("t5_andar", int'(andar_atual), 1);

        // Enable dropped mid-floor on the way to 6
        s_sh = sh_tot;
        q = {4'd6}; upd();
        tick(8);
        chk("t6_moving", int'(motor_sobe), 1);
        enable = 1'b0;
        tick(10);
        chk("t6_andar", int'(andar_atual), 3);
        chk("t6_motors", int'(motor_sobe) + int'(motor_desce), 0);
        chk("t6_state", int'(estado), 0);
        enable = 1'b1;
        wait_idle(150, "t6");
        chk("t6_final", int'(andar_atual), 6);
        chk("t6_shifts", sh_tot - s_sh, 1);
        tick(2);
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
